uart_rx: RTL and testbench

- Serial receive front end feeding the rx-side FIFO (i_data/i_stb/i_ack) in front of the UART-to-SDRAM command path.
- Samples the asynchronous rxd pin with 16x oversampling and 3-sample majority voting.
- Assembles 8N1 frames (LSB first) into a one-entry holding register.
- Presents each received byte on an stb/ack handshake; reports framing errors and overruns.

---
 rtl/uart_rx.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, 16x oversampled, 3-sample majority vote, one-entry holding register.
// Latency: o_stb rises 2 + (16*(width+1)+10)*OS_DIV clocks (+-1) after the start-bit falling edge.
// Backpressure: o_stb/o_ack handshake; a byte arriving while the register is still full is dropped with an overrun pulse.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLK_FREQ = 133000000,
    parameter int BAUD     = 115200,
    parameter int width    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             rxd,
    output logic [width-1:0] o_data,
    output logic             o_stb,
    input  logic             o_ack,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    // Clocks per oversample tick, rounded to nearest.
    localparam int OS_DIV = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
    localparam int DIV_W  = $clog2(OS_DIV);
    localparam int BC_W   = $clog2(width + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               rx_meta;
    logic               rxs;
    logic [DIV_W-1:0]   div;
    logic               tick;
    logic [3:0]         idx;
    logic [BC_W-1:0]    bit_cnt;
    logic               s7;
    logic               s8;
    logic               maj;
    logic [width-1:0]   shreg;
    logic               load_en;
    logic               ovr_en;
    logic               ferr_en;
    logic               shift_en;
    logic               bit_inc;
    logic               bit_clr;

    // Two-flop synchroniser; the line idles high so reset to 1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // Oversample divider; held at 0 in IDLE so ticks are phased to the start edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            div <= '0;
        else if (state == IDLE || tick)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    assign tick = (state != IDLE) && (div == DIV_W'(OS_DIV - 1));

    // Tick index within the current bit, plus the early majority samples.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx <= '0;
            s7  <= 1'b1;
            s8  <= 1'b1;
        end else if (state == IDLE) begin
            idx <= '0;
        end else if (tick) begin
            idx <= idx + 4'd1;
            if (idx == 4'd7)
                s7 <= rxs;
            if (idx == 4'd8)
                s8 <= rxs;
        end
    end

    // The third vote is the live rxs at tick 9.
    assign maj = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        ovr_en    = 1'b0;
        ferr_en   = 1'b0;
        shift_en  = 1'b0;
        bit_inc   = 1'b0;
        bit_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs)
                    state_nxt = START;
            end
            START: begin
                if (tick && idx == 4'd9 && maj) begin
                    state_nxt = IDLE;
                end else if (tick && idx == 4'd15) begin
                    state_nxt = DATA;
                    bit_clr   = 1'b1;
                end
            end
            DATA: begin
                if (tick && idx == 4'd9)
                    shift_en = 1'b1;
                if (tick && idx == 4'd15) begin
                    if (bit_cnt == BC_W'(width - 1))
                        state_nxt = STOP;
                    else
                        bit_inc = 1'b1;
                end
            end
            STOP: begin
                if (tick && idx == 4'd9) begin
                    if (maj) begin
                        // Leave the second half of the stop bit as slack for the next start.
                        state_nxt = IDLE;
                        if (!o_stb || o_ack)
                            load_en = 1'b1;
                        else
                            ovr_en = 1'b1;
                    end else begin
                        state_nxt = BRK;
                        ferr_en   = 1'b1;
                    end
                end
            end
            BRK: begin
                // A held-low line reports one framing error, not one per frame time.
                if (rxs)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit counter and LSB-first shift register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (bit_clr)
                bit_cnt <= '0;
            else if (bit_inc)
                bit_cnt <= bit_cnt + 1'b1;
            if (shift_en)
                shreg <= {maj, shreg[width-1:1]};
        end
    end

    // Holding register: load wins over a same-cycle accept.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_data <= '0;
            o_stb  <= 1'b0;
        end else if (load_en) begin
            o_data <= shreg;
            o_stb  <= 1'b1;
        end else if (o_stb && o_ack) begin
            o_stb  <= 1'b0;
        end
    end

    // Registered one-cycle status pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_en;
            overrun   <= ovr_en;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomised frames for uart_rx at OS_DIV=4 (64 clocks per bit).
// Expected bytes and flag counts come from a frame-level model of what was sent.
// Outputs are sampled on the falling clock edge; inputs change 1ns after the rising edge.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_FREQ = 6400000;
    localparam int BAUD     = 100000;
    localparam int W        = 8;
    localparam int BCLK     = 64;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         rxd = 1'b1;
    logic         o_ack = 1'b0;
    logic [W-1:0] o_data;
    logic         o_stb;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .width(W)) dut (
        .CLK(CLK), .RST(RST), .rxd(rxd),
        .o_data(o_data), .o_stb(o_stb), .o_ack(o_ack),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Output monitor.
    logic [7:0] rx_q[$];
    int ferr_cnt = 0, ovr_cnt = 0, stb_cyc = 0, rise_cyc = 0;
    logic prev_stb = 1'b0;
    always @(negedge CLK) begin
        if (!RST) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (o_stb && o_ack) rx_q.push_back(o_data);
            if (o_stb && !prev_stb) rise_cyc = cyc;
            if (o_stb) stb_cyc++;
        end
        prev_stb = o_stb;
    end

    int tests = 0, fails = 0;
    int fall_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (i < rx_q.size()) return {24'h0, rx_q[i]};
        return 'x;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        rxd = lvl;
        step(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
        fall_cyc = cyc;
        drive(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive(d[i], bclk);
        drive(stop, bclk);
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] pat[3];
    int f0, o0, s0, lat, bclk, gap;
    logic [7:0] d;

    initial begin
        // Reset state.
        step(3);
        check("rst_o_data", o_data, 0);
        check("rst_o_stb", o_stb, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        RST = 1'b0;
        step(20);

        // Single byte with latency.
        o_ack = 1'b1;
        f0 = ferr_cnt; o0 = ovr_cnt; s0 = stb_cyc;
        send_frame(8'hA5, 1'b1, BCLK);
        step(100);
        lat = rise_cyc - fall_cyc;
        check("a5_count", rx_q.size(), 1);
        check("a5_data", q_at(0), 8'hA5);
        check("a5_latency", (lat >= 617 && lat <= 621), 1);
        check("a5_stb_cycles", stb_cyc - s0, 1);
        check("a5_ferr", ferr_cnt - f0, 0);
        check("a5_ovr", ovr_cnt - o0, 0);
        rx_q.delete();

        // Start-bit glitch rejection.
        f0 = ferr_cnt; o0 = ovr_cnt; s0 = stb_cyc;
        rxd = 1'b0;
        step(10);
        check("glitch_busy_hi", busy, 1);
        step(10);
        rxd = 1'b1;
        step(200);
        check("glitch_busy_lo", busy, 0);
        check("glitch_stb", stb_cyc - s0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_ovr", ovr_cnt - o0, 0);

        // Framing error followed by a held-low line.
        f0 = ferr_cnt; s0 = stb_cyc;
        send_frame(8'h3C, 1'b0, BCLK);
        step(3 * BCLK);
        check("brk_busy", busy, 1);
        rxd = 1'b1;
        step(100);
        check("brk_ferr_once", ferr_cnt - f0, 1);
        check("brk_no_stb", stb_cyc - s0, 0);
        send_frame(8'h81, 1'b1, BCLK);
        step(100);
        check("post_brk_count", rx_q.size(), 1);
        check("post_brk_data", q_at(0), 8'h81);
        check("post_brk_ferr", ferr_cnt - f0, 1);
        rx_q.delete();

        // Overrun with downstream stalled.
        o_ack = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, BCLK);
        send_frame(8'h22, 1'b1, BCLK);
        step(100);
        check("ovr_pulse", ovr_cnt - o0, 1);
        check("ovr_stb_held", o_stb, 1);
        check("ovr_data_held", o_data, 8'h11);
        o_ack = 1'b1;
        step(3);
        check("ovr_drain_count", rx_q.size(), 1);
        check("ovr_drain_data", q_at(0), 8'h11);
        check("ovr_stb_clear", o_stb, 0);
        rx_q.delete();

        // Baud mismatch, slow then fast.
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                send_frame(pat[i], 1'b1, (k == 0) ? 66 : 62);
                step(40);
            end
        end
        check("skew_count", rx_q.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("skew_data%0d", i), q_at(i), pat[i % 3]);
        rx_q.delete();

        // Asynchronous reset during data bit 4, with a byte pending.
        o_ack = 1'b0;
        send_frame(8'h5A, 1'b1, BCLK);
        step(40);
        d = 8'h7E;
        drive(1'b0, BCLK);
        for (int i = 0; i < 4; i++) drive(d[i], BCLK);
        drive(d[4], BCLK / 2);
        check("pre_rst_stb", o_stb, 1);
        check("pre_rst_busy", busy, 1);
        @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        check("arst_o_data", o_data, 0);
        check("arst_o_stb", o_stb, 0);
        check("arst_busy", busy, 0);
        check("arst_flags", {frame_err, overrun}, 0);
        @(posedge CLK);
        #1;
        rxd = 1'b1;
        RST = 1'b0;
        step(50);
        o_ack = 1'b1;
        f0 = ferr_cnt;
        send_frame(8'h7E, 1'b1, BCLK);
        step(100);
        check("post_rst_count", rx_q.size(), 1);
        check("post_rst_data", q_at(0), 8'h7E);
        check("post_rst_ferr", ferr_cnt - f0, 0);
        rx_q.delete();

        // Random bytes, random in-tolerance bit period and inter-frame gap.
        f0 = ferr_cnt; o0 = ovr_cnt;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            bclk = $urandom_range(62, 66);
            gap = $urandom_range(1, 40);
            exp_q.push_back(d);
            send_frame(d, 1'b1, bclk);
            step(gap);
        end
        step(100);
        check("rand_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) check($sformatf("rand_data%0d", i), q_at(i), exp_q[i]);
        check("rand_ferr", ferr_cnt - f0, 0);
        check("rand_ovr", ovr_cnt - o0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
